// File: rtl/product_accumulator_pkg.sv
// Shared defaults and FSM encodings for the product accumulate stage.
package product_accumulator_pkg;

    localparam int PA_PW = 32;
    localparam int PA_AW = 40;
    localparam int PA_CW = 16;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

endpackage

// File: rtl/acc_sat_adder.sv
// Combinational AW-bit unsigned add with carry-out and optional clamp to all ones.
module acc_sat_adder
    import product_accumulator_pkg::*;
#(
    parameter int AW  = PA_AW,
    parameter bit SAT = 1'b1
) (
    input  logic [AW-1:0] a,
    input  logic [AW-1:0] b,
    output logic [AW-1:0] sum,
    output logic          ovf
);

    logic [AW:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b};

    // Carry-out is the overflow; clamp only when saturation is enabled.
    always_comb begin
        ovf = w_full[AW];
        if (SAT && w_full[AW]) begin
            sum = '1;
        end else begin
            sum = w_full[AW-1:0];
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products: sums in_first..in_last beats into one
// registered result with sticky overflow and saturating beat count.
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PW  = PA_PW,
    parameter int AW  = PA_AW,
    parameter int CW  = PA_CW,
    parameter bit SAT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_prod,
    input  logic          in_first,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_acc,
    output logic          out_ovf,
    output logic [CW-1:0] out_count,
    output logic          frame_drop
);

    logic          r_state;
    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_out_valid;
    logic [AW-1:0] r_out_acc;
    logic          r_out_ovf;
    logic [CW-1:0] r_out_count;
    logic          r_frame_drop;

    logic          w_accept;
    logic          w_start;
    logic [AW-1:0] w_prod;
    logic [AW-1:0] w_sum;
    logic          w_add_ovf;
    logic [AW-1:0] w_acc_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_ovf_nxt;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_prod   = AW'(in_prod);
    // Any beat arriving with no frame open starts one, whatever in_first says.
    assign w_start  = (r_state == ST_IDLE) || in_first;

    acc_sat_adder #(
        .AW  (AW),
        .SAT (SAT)
    ) u_add (
        .a   (r_acc),
        .b   (w_prod),
        .sum (w_sum),
        .ovf (w_add_ovf)
    );

    // Running-frame values including the beat currently offered.
    always_comb begin
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (w_start) begin
            w_acc_nxt = w_prod;
            w_cnt_nxt = CW'(1'b1);
            w_ovf_nxt = 1'b0;
        end else begin
            w_acc_nxt = w_sum;
            w_ovf_nxt = r_ovf || w_add_ovf;
            if (r_cnt == '1) begin
                w_cnt_nxt = r_cnt;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1'b1);
            end
        end
    end

    // Frame state, accumulator registers and the abandoned-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            r_frame_drop <= w_accept && in_first && (r_state == ST_ACTIVE);
            if (w_accept) begin
                r_acc <= w_acc_nxt;
                r_cnt <= w_cnt_nxt;
                r_ovf <= w_ovf_nxt;
                if (in_last) begin
                    r_state <= ST_IDLE;
                end else begin
                    r_state <= ST_ACTIVE;
                end
            end else begin
                r_state <= r_state;
            end
        end
    end

    // Single-entry result register; a reload wins over a same-cycle handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_count <= '0;
        end else if (w_accept && in_last) begin
            r_out_valid <= 1'b1;
            r_out_acc   <= w_acc_nxt;
            r_out_ovf   <= w_ovf_nxt;
            r_out_count <= w_cnt_nxt;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_acc    = r_out_acc;
    assign out_ovf    = r_out_ovf;
    assign out_count  = r_out_count;
    assign frame_drop = r_frame_drop;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed bench for product_accumulator (40-bit saturating plus
// 33-bit saturating and wrapping instances sharing one input stream).
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        in_first;
    logic        in_last;
    logic        out_ready;

    logic        in_ready, out_valid, out_ovf, frame_drop;
    logic [39:0] out_acc;
    logic [15:0] out_count;
    logic        in_ready_s, out_valid_s, out_ovf_s, frame_drop_s;
    logic [32:0] out_acc_s;
    logic [15:0] out_count_s;
    logic        in_ready_w, out_valid_w, out_ovf_w, frame_drop_w;
    logic [32:0] out_acc_w;
    logic [15:0] out_count_w;

    always #5 clk = ~clk;

    product_accumulator #(.PW(32), .AW(40), .CW(16), .SAT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_ovf(out_ovf), .out_count(out_count), .frame_drop(frame_drop));

    product_accumulator #(.PW(32), .AW(33), .CW(16), .SAT(1'b1)) u_sat33 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_prod(in_prod), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_acc(out_acc_s),
        .out_ovf(out_ovf_s), .out_count(out_count_s), .frame_drop(frame_drop_s));

    product_accumulator #(.PW(32), .AW(33), .CW(16), .SAT(1'b0)) u_wrap33 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_prod(in_prod), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_acc(out_acc_w),
        .out_ovf(out_ovf_w), .out_count(out_count_w), .frame_drop(frame_drop_w));

    typedef struct {
        logic [63:0] acc;
        logic [63:0] acc_s;
        logic [63:0] acc_w;
        bit          ovf;
        bit          ovf_s;
        bit          ovf_w;
        int          cnt;
        int          cyc;
    } res_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    res_t        cap_q[$];
    res_t        exp_q[$];
    res_t        cap_r;
    int          drop_log[$];
    int          ov_cycles;
    int          exp_drops;
    logic [63:0] frame_q[$];
    bit          m_open;
    bit          rand_rdy = 1'b0;
    int          b_cyc;
    bit          b_stalled;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Output monitor: records every result handshake and every drop pulse.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            cap_r.acc   = 64'(out_acc);
            cap_r.acc_s = 64'(out_acc_s);
            cap_r.acc_w = 64'(out_acc_w);
            cap_r.ovf   = out_ovf;
            cap_r.ovf_s = out_ovf_s;
            cap_r.ovf_w = out_ovf_w;
            cap_r.cnt   = int'(out_count);
            cap_r.cyc   = cyc;
            cap_q.push_back(cap_r);
        end
        if (out_valid) ov_cycles++;
        if (frame_drop) drop_log.push_back(cyc);
    end

    // Reference: fold the frame's products in order under an AW-bit accumulator.
    function automatic void fold(input int aw, input bit sat,
                                 output logic [63:0] acc, output bit ovf);
        logic [63:0] mx;
        logic [63:0] s;
        mx  = (64'd1 << aw) - 64'd1;
        acc = frame_q[0];
        ovf = 1'b0;
        for (int i = 1; i < frame_q.size(); i++) begin
            s = acc + frame_q[i];
            if (s > mx) begin
                ovf = 1'b1;
                acc = sat ? mx : (s & mx);
            end else begin
                acc = s;
            end
        end
    endfunction

    task automatic model_beat(input logic [31:0] p, input bit f, input bit l);
        res_t e;
        if (!m_open || f) begin
            if (m_open) exp_drops++;
            frame_q.delete();
        end
        frame_q.push_back(64'(p));
        if (l) begin
            fold(40, 1'b1, e.acc, e.ovf);
            fold(33, 1'b1, e.acc_s, e.ovf_s);
            fold(33, 1'b0, e.acc_w, e.ovf_w);
            e.cnt = (frame_q.size() > 65535) ? 65535 : frame_q.size();
            e.cyc = 0;
            exp_q.push_back(e);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    task automatic beat(input logic [31:0] p, input bit f, input bit l);
        int waits;
        @(negedge clk);
        in_valid = 1'b1;
        in_prod  = p;
        in_first = f;
        in_last  = l;
        #1;
        waits     = 0;
        b_stalled = 1'b0;
        while (!in_ready && waits < 200) begin
            b_stalled = 1'b1;
            @(negedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waits);
        end
        b_cyc = cyc;
        @(posedge clk);
        model_beat(p, f, l);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #3;
            if (!out_valid) break;
        end
        if (out_valid) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic clr();
        cap_q.delete();
        exp_q.delete();
        drop_log.delete();
        ov_cycles = 0;
        exp_drops = 0;
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0; in_valid = 1'b0; in_prod = 32'd0; in_first = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        m_open = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({out_valid, out_ovf, frame_drop, in_ready} !== 4'b0001 || out_acc !== 40'd0 ||
            out_count !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: vld/ovf/drop/rdy=%b acc=%0d cnt=%0d, want 0001 0 0",
                     {out_valid, out_ovf, frame_drop, in_ready}, out_acc, out_count);
        end
        @(negedge clk) rst_n = 1'b1;
        clr();
        beat(32'd10, 1'b1, 1'b0);
        beat(32'd11, 1'b0, 1'b0);
        beat(32'd12, 1'b1, 1'b0);
        k = b_cyc;
        n_cmp++;
        if (frame_drop !== 1'b1) begin
            n_err++;
            $display("FAIL drop_before_reset: frame_drop=%b, want 1", frame_drop);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (frame_drop !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: frame_drop=%b, want 0", frame_drop);
        end
        frame_q.delete();
        m_open = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clr();
        beat(32'd7, 1'b1, 1'b1);
        k = b_cyc;
        drain();
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc !== 64'd7 || cap_q[0].cnt != 1 ||
            cap_q[0].ovf !== 1'b0 || drop_log.size() != 0) begin
            n_err++;
            $display("FAIL after_reset: n=%0d acc=%0d cnt=%0d ovf=%b drops=%0d, want 1 7 1 0 0",
                     cap_q.size(), cap_q.size() ? cap_q[0].acc : 64'd0,
                     cap_q.size() ? cap_q[0].cnt : 0, cap_q.size() ? cap_q[0].ovf : 1'b0,
                     drop_log.size());
        end
    endtask

    task automatic test_frame3();
        int k;
        clr();
        out_ready = 1'b1;
        beat(32'd100, 1'b1, 1'b0);
        beat(32'd200, 1'b0, 1'b0);
        beat(32'd300, 1'b0, 1'b1);
        k = b_cyc;
        drain();
        n_cmp++;
        if (cap_q.size() != 1 || ov_cycles != 1) begin
            n_err++;
            $display("FAIL frame3_pulse: results=%0d valid_cycles=%0d, want 1 1", cap_q.size(), ov_cycles);
        end else begin
            n_cmp++;
            if (cap_q[0].acc !== 64'd600 || cap_q[0].cnt != 3 || cap_q[0].ovf !== 1'b0 ||
                cap_q[0].cyc != k + 1) begin
                n_err++;
                $display("FAIL frame3_result: acc=%0d cnt=%0d ovf=%b lat=%0d, want 600 3 0 1",
                         cap_q[0].acc, cap_q[0].cnt, cap_q[0].ovf, cap_q[0].cyc - k);
            end
        end
    endtask

    task automatic test_overflow();
        clr();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) beat(32'hFFFF_FFFF, i == 0, i == 2);
        drain();
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc_s !== 64'h1_FFFF_FFFF || cap_q[0].ovf_s !== 1'b1) begin
            n_err++;
            $display("FAIL ovf33_sat: n=%0d acc=%h ovf=%b, want 1 1ffffffff 1", cap_q.size(),
                     cap_q.size() ? cap_q[0].acc_s : 64'd0, cap_q.size() ? cap_q[0].ovf_s : 1'b0);
        end
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc_w !== 64'h0_FFFF_FFFD || cap_q[0].ovf_w !== 1'b1) begin
            n_err++;
            $display("FAIL ovf33_wrap: acc=%h ovf=%b, want fffffffd 1",
                     cap_q.size() ? cap_q[0].acc_w : 64'd0, cap_q.size() ? cap_q[0].ovf_w : 1'b0);
        end
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc !== 64'h2_FFFF_FFFD || cap_q[0].ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf40_none: acc=%h ovf=%b, want 2fffffffd 0",
                     cap_q.size() ? cap_q[0].acc : 64'd0, cap_q.size() ? cap_q[0].ovf : 1'b0);
        end
        clr();
        for (int i = 0; i < 257; i++) beat(32'hFFFF_FFFF, i == 0, 1'b0);
        beat(32'd0, 1'b0, 1'b1);
        drain();
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc !== 64'hFF_FFFF_FFFF || cap_q[0].ovf !== 1'b1 ||
            cap_q[0].cnt != 258) begin
            n_err++;
            $display("FAIL ovf40_sticky: acc=%h ovf=%b cnt=%0d, want ffffffffff 1 258",
                     cap_q.size() ? cap_q[0].acc : 64'd0, cap_q.size() ? cap_q[0].ovf : 1'b0,
                     cap_q.size() ? cap_q[0].cnt : 0);
        end
    endtask

    task automatic test_stall();
        bit stalled5;
        clr();
        @(negedge clk) out_ready = 1'b0;
        beat(32'd9, 1'b1, 1'b1);
        fork
            begin
                beat(32'd5, 1'b1, 1'b0);
                stalled5 = b_stalled;
                beat(32'd6, 1'b0, 1'b1);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    #2;
                    n_cmp++;
                    if (out_valid !== 1'b1 || out_acc !== 40'd9 || in_ready !== 1'b0) begin
                        n_err++;
                        $display("FAIL stall_hold: vld=%b acc=%0d rdy=%b, want 1 9 0",
                                 out_valid, out_acc, in_ready);
                    end
                end
                @(negedge clk) out_ready = 1'b1;
            end
        join
        drain();
        n_cmp++;
        if (!stalled5 || cap_q.size() != 2 || cap_q[0].acc !== 64'd9 || cap_q[1].acc !== 64'd11 ||
            cap_q[1].cnt != 2) begin
            n_err++;
            $display("FAIL stall_results: stalled=%b n=%0d first=%0d second=%0d, want 1 2 9 11",
                     stalled5, cap_q.size(), cap_q.size() > 0 ? cap_q[0].acc : 64'd0,
                     cap_q.size() > 1 ? cap_q[1].acc : 64'd0);
        end
    endtask

    task automatic test_drop();
        int k;
        clr();
        out_ready = 1'b1;
        beat(32'd10, 1'b1, 1'b0);
        beat(32'd20, 1'b0, 1'b0);
        beat(32'd4, 1'b1, 1'b0);
        k = b_cyc;
        beat(32'd8, 1'b0, 1'b1);
        drain();
        n_cmp++;
        if (drop_log.size() != 1 || drop_log[0] != k + 1) begin
            n_err++;
            $display("FAIL drop_pulse: pulses=%0d at=%0d, want 1 at %0d", drop_log.size(),
                     drop_log.size() ? drop_log[0] : -1, k + 1);
        end
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].acc !== 64'd12 || cap_q[0].cnt != 2 || cap_q[0].ovf !== 1'b0) begin
            n_err++;
            $display("FAIL drop_result: n=%0d acc=%0d cnt=%0d, want 1 12 2", cap_q.size(),
                     cap_q.size() ? cap_q[0].acc : 64'd0, cap_q.size() ? cap_q[0].cnt : 0);
        end
    endtask

    task automatic test_back_to_back();
        int  k[3];
        bit  st;
        clr();
        out_ready = 1'b1;
        st = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat(32'(i + 1), 1'b1, 1'b1);
            k[i] = b_cyc;
            st |= b_stalled;
        end
        drain();
        n_cmp++;
        if (st || k[1] != k[0] + 1 || k[2] != k[1] + 1) begin
            n_err++;
            $display("FAIL b2b_ready: stalled=%b gaps=%0d,%0d, want 0 1,1", st, k[1] - k[0], k[2] - k[1]);
        end
        n_cmp++;
        if (cap_q.size() != 3) begin
            n_err++;
            $display("FAIL b2b_count: results=%0d, want 3", cap_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (cap_q[i].acc !== 64'(i + 1) || cap_q[i].cyc != k[0] + 1 + i) begin
                    n_err++;
                    $display("FAIL b2b_result%0d: acc=%0d cyc=%0d, want %0d %0d", i,
                             cap_q[i].acc, cap_q[i].cyc, i + 1, k[0] + 1 + i);
                end
            end
        end
    endtask

    task automatic test_count_sat();
        clr();
        out_ready = 1'b1;
        for (int i = 0; i < 65537; i++) beat(32'd1, i == 0, i == 65536);
        drain();
        n_cmp++;
        if (cap_q.size() != 1 || cap_q[0].cnt != 65535 || cap_q[0].acc !== 64'd65537) begin
            n_err++;
            $display("FAIL count_sat: cnt=%0d acc=%0d, want 65535 65537",
                     cap_q.size() ? cap_q[0].cnt : 0, cap_q.size() ? cap_q[0].acc : 64'd0);
        end
    endtask

    task automatic test_random();
        logic [31:0] p;
        clr();
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            beat(p, $urandom_range(0, 6) == 0, $urandom_range(0, 3) == 0);
        end
        beat(32'($urandom), 1'b0, 1'b1);
        drain();
        n_cmp++;
        if (cap_q.size() != exp_q.size() || drop_log.size() != exp_drops) begin
            n_err++;
            $display("FAIL rand_counts: results=%0d drops=%0d, want %0d %0d",
                     cap_q.size(), drop_log.size(), exp_q.size(), exp_drops);
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (cap_q[i].acc !== exp_q[i].acc || cap_q[i].ovf !== exp_q[i].ovf ||
                cap_q[i].acc_s !== exp_q[i].acc_s || cap_q[i].ovf_s !== exp_q[i].ovf_s ||
                cap_q[i].acc_w !== exp_q[i].acc_w || cap_q[i].ovf_w !== exp_q[i].ovf_w ||
                cap_q[i].cnt != exp_q[i].cnt) begin
                n_err++;
                $display("FAIL rand_frame%0d: acc=%h/%h/%h ovf=%b%b%b cnt=%0d, want %h/%h/%h %b%b%b %0d",
                         i, cap_q[i].acc, cap_q[i].acc_s, cap_q[i].acc_w, cap_q[i].ovf,
                         cap_q[i].ovf_s, cap_q[i].ovf_w, cap_q[i].cnt, exp_q[i].acc,
                         exp_q[i].acc_s, exp_q[i].acc_w, exp_q[i].ovf, exp_q[i].ovf_s,
                         exp_q[i].ovf_w, exp_q[i].cnt);
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_frame3();
        test_overflow();
        test_stall();
        test_drop();
        test_back_to_back();
        test_count_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
